// File: rtl/jtframe_joyser_pkg.sv
// jtframe_joyser_pkg: shared state encoding and slot helpers for the
// DB15 serial joystick poller.
package jtframe_joyser_pkg;

    // Width of one joystick word presented to the frame
    localparam int JOYW = 16;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_LOAD,
        ST_SETTLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } joyser_state_e;

    // Bit base of player p inside a packed joystick bus
    function automatic int slot(input int p);
        return p * JOYW;
    endfunction

    // Integer maximum, used to size the shared half-period counter
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jtframe_joyser_sync.sv
// jtframe_joyser_sync: two-flop synchroniser for asynchronous pins.
// Resets to RST_VAL so an idle (pulled-up) pin reads as inactive.
module jtframe_joyser_sync
    import jtframe_joyser_pkg::*;
#(
    parameter int              WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // Next values simply step the pin through the two stages
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchroniser stages, reset to the idle pin level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/jtframe_joyser.sv
// jtframe_joyser: polls a 74HC165 chain and muxes serial vs USB joysticks.
// Optional: define JTFRAME_JOYSER_DEBOUNCE_EN to require two equal frames.
module jtframe_joyser
    import jtframe_joyser_pkg::*;
#(
    parameter int PLAYERS = 2,
    parameter int BITS    = 12,
    parameter int CLKDIV  = 24,
    parameter int GAP     = 1024
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    output logic                    JOY_CLK,
    output logic                    JOY_LOAD,
    input  logic                    JOY_DATA,
    input  logic [16*PLAYERS-1:0]   usb_joy,
    input  logic [PLAYERS-1:0]      src_sel,
    output logic [16*PLAYERS-1:0]   joy_ser,
    output logic [16*PLAYERS-1:0]   joystick,
    output logic                    frame_done
);

    localparam int TOTAL = PLAYERS * BITS;
    localparam int W     = JOYW * PLAYERS;
    localparam int CMAX  = imax(CLKDIV, GAP);
    localparam int CW    = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int KW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(TOTAL - 1);

    joyser_state_e    state_q;
    joyser_state_e    state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [KW-1:0]    k_q;
    logic [KW-1:0]    k_d;
    logic [TOTAL-1:0] shift_q;
    logic [TOTAL-1:0] shift_d;
    logic [W-1:0]     ser_q;
    logic [W-1:0]     ser_d;
    logic [W-1:0]     joystick_q;
    logic [W-1:0]     joystick_d;
    logic             done_q;
    logic             done_d;
    logic             jclk_q;
    logic             jclk_d;
    logic             jload_q;
    logic             jload_d;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
    logic [W-1:0]     prev_q;
    logic [W-1:0]     prev_d;
`endif

    logic             data_s;
    logic             cnt_last;
    logic [W-1:0]     frame_w;

    jtframe_joyser_sync #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk_sys),
        .rst (rst),
        .d   (JOY_DATA),
        .q   (data_s)
    );

    // Re-pack the serial stream into slots; unused upper bits stay zero,
    // and each output slot picks the serial or USB word.
    for (genvar p = 0; p < PLAYERS; p++) begin : g_slot
        localparam int B0 = slot(p);

        assign frame_w[B0 +: BITS] = shift_q[p*BITS +: BITS];

        if (BITS < JOYW) begin : g_pad
            assign frame_w[B0+BITS +: JOYW-BITS] = '0;
        end

        assign joystick_d[B0 +: JOYW] = src_sel[p] ?
                                        ser_q[B0 +: JOYW] :
                                        usb_joy[B0 +: JOYW];
    end

    // Current state has spent its full duration
    always_comb begin
        cnt_last = (state_q == ST_GAP) ? (cnt_q == GAP_LAST)
                                       : (cnt_q == DIV_LAST);
    end

    // Frame sequencer: gap, load, settle, then LOW/HIGH per bit, done
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        k_d     = k_q;
        shift_d = shift_q;
        ser_d   = ser_q;
        done_d  = 1'b0;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
        prev_d  = prev_q;
`endif
        unique case (state_q)
            ST_GAP: begin
                if (cnt_last) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (cnt_last) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_last) begin
                    state_d = ST_LOW;
                    k_d     = '0;
                end
            end
            ST_LOW: begin
                if (cnt_last) begin
                    shift_d[k_q] = ~data_s;
                    state_d      = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_last) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = ST_LOW;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_GAP;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
                prev_d = frame_w;
                if (frame_w == prev_q) begin
                    ser_d  = frame_w;
                    done_d = 1'b1;
                end
`else
                ser_d  = frame_w;
                done_d = 1'b1;
`endif
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
        // Every state starts timing from zero on entry
        if (state_d != state_q) cnt_d = '0;
        jclk_d  = (state_d == ST_HIGH);
        jload_d = (state_d != ST_LOAD);
    end

    // Sequencer, frame and output registers
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= ST_GAP;
            cnt_q      <= '0;
            k_q        <= '0;
            shift_q    <= '0;
            ser_q      <= '0;
            joystick_q <= '0;
            done_q     <= 1'b0;
            jclk_q     <= 1'b0;
            jload_q    <= 1'b1;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
            prev_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            shift_q    <= shift_d;
            ser_q      <= ser_d;
            joystick_q <= joystick_d;
            done_q     <= done_d;
            jclk_q     <= jclk_d;
            jload_q    <= jload_d;
`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
            prev_q     <= prev_d;
`endif
        end
    end

    assign JOY_CLK    = jclk_q;
    assign JOY_LOAD   = jload_q;
    assign joy_ser    = ser_q;
    assign joystick   = joystick_q;
    assign frame_done = done_q;

endmodule
